// File: rtl/sme_stream_loader.sv
// Buffers string/pattern records from a ready/valid byte stream and replays each one to the
// SME as a single gap-free burst. Define SME_LOADER_TIMEOUT_EN to add a WAIT_MATCH watchdog.
module sme_stream_loader #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8
`ifdef SME_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_type,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_err
);

  localparam int AW = $clog2(STR_MAX);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, COLLECT, REPLAY, WAIT_MATCH, RESULT} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d, rd_ptr_q, rd_ptr_d;
  logic          is_pat_q, is_pat_d, ovf_q, ovf_d, str_loaded_q, str_loaded_d;
  logic          in_ready_q, in_ready_d, isstring_q, isstring_d, ispattern_q, ispattern_d;
  logic [7:0]    chardata_q, chardata_d;
  logic          res_valid_q, res_valid_d, res_match_q, res_match_d, res_err_q, res_err_d;
  logic [4:0]    res_index_q, res_index_d;
`ifdef SME_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  logic [7:0]    buf_mem [STR_MAX];
  logic          buf_we;
  logic [AW-1:0] buf_wa;
  logic          accept, rec_pat, rec_ovf;
  logic [LW-1:0] limit, rec_len;

  // NOTE: every *_d and helper gets a default at the top, so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    rd_ptr_d     = rd_ptr_q;
    is_pat_d     = is_pat_q;
    ovf_d        = ovf_q;
    str_loaded_d = str_loaded_q;
    in_ready_d   = in_ready_q;
    isstring_d   = isstring_q;
    ispattern_d  = ispattern_q;
    chardata_d   = chardata_q;
    res_valid_d  = res_valid_q;
    res_match_d  = res_match_q;
    res_index_d  = res_index_q;
    res_err_d    = res_err_q;
`ifdef SME_LOADER_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    buf_we  = 1'b0;
    buf_wa  = len_q[AW-1:0];
    accept  = in_valid & in_ready_q;
    rec_pat = (state_q == IDLE) ? in_type : is_pat_q;
    limit   = rec_pat ? LW'(PAT_MAX) : LW'(STR_MAX);
    rec_ovf = ovf_q;
    rec_len = len_q;

    case (state_q)
      // IDLE only differs from COLLECT in where the record type comes from; len_q is 0 there.
      IDLE, COLLECT: begin
        if (accept) begin
          is_pat_d = rec_pat;
          if (len_q < limit) begin
            buf_we  = 1'b1;
            rec_len = len_q + LW'(1);
          end else begin
            rec_ovf = 1'b1;
          end
          len_d   = rec_len;
          ovf_d   = rec_ovf;
          state_d = COLLECT;
          if (in_last) begin
            in_ready_d = 1'b0;
            if (rec_ovf || (rec_pat && !str_loaded_q)) begin
              state_d     = RESULT;
              res_valid_d = 1'b1;
              res_err_d   = 1'b1;
              res_match_d = 1'b0;
              res_index_d = '0;
            end else begin
              // First burst byte leaves on the next edge; a one-byte record bypasses the buffer.
              state_d     = REPLAY;
              isstring_d  = !rec_pat;
              ispattern_d = rec_pat;
              chardata_d  = (len_q == '0) ? in_data : buf_mem[0];
              rd_ptr_d    = LW'(1);
            end
          end
        end
      end
      REPLAY: begin
        if (rd_ptr_q < len_q) begin
          chardata_d = buf_mem[rd_ptr_q[AW-1:0]];
          rd_ptr_d   = rd_ptr_q + LW'(1);
        end else begin
          isstring_d  = 1'b0;
          ispattern_d = 1'b0;
          if (is_pat_q) begin
            state_d = WAIT_MATCH;
`ifdef SME_LOADER_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            state_d      = IDLE;
            str_loaded_d = 1'b1;
            in_ready_d   = 1'b1;
            len_d        = '0;
          end
        end
      end
      WAIT_MATCH: begin
        if (sme_valid) begin
          state_d     = RESULT;
          res_valid_d = 1'b1;
          res_match_d = sme_match;
          res_index_d = sme_match ? sme_index : 5'd0;
          res_err_d   = 1'b0;
        end
`ifdef SME_LOADER_TIMEOUT_EN
        else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESULT;
          res_valid_d = 1'b1;
          res_match_d = 1'b0;
          res_index_d = '0;
          res_err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      RESULT: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          ovf_d       = 1'b0;
          len_d       = '0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops update only with non-blocking '<='; the always_comb above uses blocking '='.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      rd_ptr_q     <= '0;
      is_pat_q     <= 1'b0;
      ovf_q        <= 1'b0;
      str_loaded_q <= 1'b0;
      in_ready_q   <= 1'b1;
      isstring_q   <= 1'b0;
      ispattern_q  <= 1'b0;
      chardata_q   <= '0;
      res_valid_q  <= 1'b0;
      res_match_q  <= 1'b0;
      res_index_q  <= '0;
      res_err_q    <= 1'b0;
`ifdef SME_LOADER_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rd_ptr_q     <= rd_ptr_d;
      is_pat_q     <= is_pat_d;
      ovf_q        <= ovf_d;
      str_loaded_q <= str_loaded_d;
      in_ready_q   <= in_ready_d;
      isstring_q   <= isstring_d;
      ispattern_q  <= ispattern_d;
      chardata_q   <= chardata_d;
      res_valid_q  <= res_valid_d;
      res_match_q  <= res_match_d;
      res_index_q  <= res_index_d;
      res_err_q    <= res_err_d;
`ifdef SME_LOADER_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  // NOTE: the record buffer is not reset; every slot is written before REPLAY reads it.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[buf_wa] <= in_data;
  end

  assign in_ready  = in_ready_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign chardata  = chardata_q;
  assign res_valid = res_valid_q;
  assign res_match = res_match_q;
  assign res_index = res_index_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_sme_stream_loader.sv
// Scoreboard bench for sme_stream_loader: a record-level model queues the expected SME bursts
// and results, independent monitors pop and compare whatever the loader presents.
module tb_sme_stream_loader;

  localparam int STR_MAX = 32;
  localparam int PAT_MAX = 8;

  typedef logic [7:0] bq_t[$];
  typedef struct { bit pat; logic [7:0] data; bit last; } burst_t;
  typedef struct { bit match; logic [4:0] index; bit err; } res_t;
  typedef struct { bit match; logic [4:0] index; bit silent; } sme_t;

  logic       clk, reset;
  logic       in_valid, in_ready, in_type, in_last;
  logic [7:0] in_data, chardata;
  logic       isstring, ispattern;
  logic       sme_valid, sme_match;
  logic [4:0] sme_index;
  logic       res_valid, res_ready, res_match, res_err;
  logic [4:0] res_index;

  sme_stream_loader dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_type(in_type),
    .in_last(in_last),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .sme_valid(sme_valid), .sme_match(sme_match), .sme_index(sme_index),
    .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
    .res_index(res_index), .res_err(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  burst_t burst_q[$];
  res_t   res_q[$];
  sme_t   sme_q[$];
  bit     model_loaded = 1'b0;
  bit     flushing = 1'b0;
  bit     rdy_random = 1'b1;
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  task automatic send_byte(input bit t, input logic [7:0] d, input bit last);
    int guard = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1; in_type = t; in_data = d; in_last = last;
    while (!in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) fail("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  // Reference model: decide the record's fate from its length, type and load history.
  task automatic issue_record(input bit is_pat, input bq_t bytes, input bit fix,
                              input bit fmatch, input logic [4:0] fidx, input bit silent);
    int   limit = is_pat ? PAT_MAX : STR_MAX;
    bit   err = (bytes.size() > limit) || (is_pat && !model_loaded);
    sme_t s;
    if (err) begin
      res_q.push_back('{match: 1'b0, index: 5'd0, err: 1'b1});
    end else begin
      for (int i = 0; i < bytes.size(); i++)
        burst_q.push_back('{pat: is_pat, data: bytes[i], last: (i == bytes.size() - 1)});
      if (!is_pat) begin
        model_loaded = 1'b1;
      end else begin
        s.match  = fix ? fmatch : 1'($urandom_range(0, 1));
        s.index  = fix ? fidx : 5'($urandom_range(0, 31));
        s.silent = silent;
        sme_q.push_back(s);
        if (!silent) res_q.push_back('{match: s.match, index: (s.match ? s.index : 5'd0), err: 1'b0});
`ifdef SME_LOADER_TIMEOUT_EN
        else res_q.push_back('{match: 1'b0, index: 5'd0, err: 1'b1});
`endif
      end
    end
    for (int i = 0; i < bytes.size(); i++)
      send_byte((i == 0) ? is_pat : 1'($urandom_range(0, 1)), bytes[i], i == bytes.size() - 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((burst_q.size() != 0 || res_q.size() != 0 || sme_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) fail("drain_timeout", burst_q.size() + res_q.size() + sme_q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  // Burst monitor: every strobe cycle must match the next queued byte, with no gaps inside a burst.
  initial begin
    burst_t b;
    bit exp_more = 1'b0;
    bit after_last = 1'b0;
    forever begin
      @(negedge clk);
      if (flushing || reset) begin
        exp_more = 1'b0;
        after_last = 1'b0;
      end else if (isstring || ispattern) begin
        if (isstring && ispattern) fail("both_strobes", 2'b11, 2'b01);
        if (after_last) fail("burst_overrun", 1, 0);
        if (burst_q.size() == 0) begin
          fail("unexpected_strobe", chardata, 0);
          after_last = 1'b0;
        end else begin
          b = burst_q.pop_front();
          check("burst_type", ispattern, b.pat);
          check("burst_data", chardata, b.data);
          exp_more = !b.last;
          after_last = b.last;
        end
      end else begin
        if (exp_more) fail("burst_gap", 0, 1);
        exp_more = 1'b0;
        after_last = 1'b0;
      end
    end
  end

  // Result monitor: compare on handshake, and require stability while the consumer stalls.
  initial begin
    res_t e;
    bit pv = 1'b0;
    logic [6:0] prev = '0;
    forever begin
      @(negedge clk);
      if (flushing || reset) begin
        pv = 1'b0;
      end else if (res_valid) begin
        if (pv) check("res_stable", {res_match, res_index, res_err}, prev);
        if (res_ready) begin
          if (res_q.size() == 0) begin
            fail("unexpected_result", {res_match, res_index, res_err}, 0);
          end else begin
            e = res_q.pop_front();
            check("res_match", res_match, e.match);
            check("res_index", res_index, e.index);
            check("res_err", res_err, e.err);
          end
          pv = 1'b0;
        end else begin
          pv = 1'b1;
          prev = {res_match, res_index, res_err};
        end
      end else begin
        if (pv) fail("res_valid_dropped", 0, 1);
        pv = 1'b0;
      end
    end
  end

  // SME model: answers each completed pattern burst after a short random delay.
  initial begin
    sme_t r;
    bit prev_pat = 1'b0;
    sme_valid = 1'b0; sme_match = 1'b0; sme_index = '0;
    forever begin
      @(negedge clk);
      if (prev_pat && !ispattern && !flushing && sme_q.size() != 0) begin
        r = sme_q.pop_front();
        if (!r.silent) begin
          repeat ($urandom_range(0, 4)) @(negedge clk);
          sme_valid = 1'b1; sme_match = r.match; sme_index = r.index;
          @(negedge clk);
          sme_valid = 1'b0;
          sme_match = 1'($urandom_range(0, 1));
          sme_index = 5'($urandom_range(0, 31));
        end
      end
      prev_pat = ispattern;
    end
  end

  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_random) res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int n;
    int seen;
    bit t;
    int len;
    in_valid = 1'b0; in_type = 1'b0; in_data = '0; in_last = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_strobes", {isstring, ispattern}, 0);
    check("rst_chardata", chardata, 0);
    check("rst_res", {res_valid, res_match, res_index, res_err}, 0);
    @(negedge clk);
    reset = 1'b0;

    // Error records: pattern before any string, oversize string, oversize pattern.
    issue_record(1'b1, str2q("^xy"), 1'b0, 1'b0, 5'd0, 1'b0);
    issue_record(1'b0, rand_bytes(33), 1'b0, 1'b0, 5'd0, 1'b0);
    issue_record(1'b1, rand_bytes(9), 1'b0, 1'b0, 5'd0, 1'b0);
    drain();

    issue_record(1'b0, str2q("abc de"), 1'b0, 1'b0, 5'd0, 1'b0);
    n = 0;
    while (!(isstring || ispattern) && n < 50) begin @(posedge clk); #1; n++; end
    while ((isstring || ispattern) && n < 100) begin @(posedge clk); #1; n++; end
    check("in_ready_after_string", in_ready, 1);

    rdy_random = 1'b0;
    res_ready = 1'b0;
    issue_record(1'b1, str2q("de"), 1'b1, 1'b1, 5'd4, 1'b0);
    n = 0;
    while (!res_valid && n < 200) begin @(posedge clk); #1; n++; end
    check("match_res_valid", res_valid, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("held_res", {res_valid, res_match, res_index, res_err}, {1'b1, 1'b1, 5'd4, 1'b0});
    end
    rdy_random = 1'b1;

    issue_record(1'b1, str2q("bc"), 1'b1, 1'b0, 5'd7, 1'b0);
    drain();

    // Random records, lengths clustered around the buffer limits.
    for (int r = 0; r < 24; r++) begin
      t = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0)
        len = (t ? PAT_MAX : STR_MAX) + $urandom_range(0, 2) - 1;
      else
        len = $urandom_range(1, t ? PAT_MAX : STR_MAX);
      issue_record(t, rand_bytes(len), 1'b0, 1'b0, 5'd0, 1'b0);
    end
    drain();

    // Reset in the middle of a full-length string replay.
    issue_record(1'b0, rand_bytes(32), 1'b0, 1'b0, 5'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("replay_active", isstring, 1);
    #2;
    flushing = 1'b1;
    reset = 1'b1;
    #1;
    check("reset_kills_strobe", {isstring, ispattern}, 0);
    burst_q.delete();
    res_q.delete();
    sme_q.delete();
    model_loaded = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", in_ready, 1);
    flushing = 1'b0;

    // A pattern the SME never answers.
    issue_record(1'b0, str2q("ab"), 1'b0, 1'b0, 5'd0, 1'b0);
    issue_record(1'b1, str2q("zz"), 1'b0, 1'b0, 5'd0, 1'b1);
    n = 0;
    while (ispattern && n < 100) begin @(posedge clk); #1; n++; end
    check("pattern_burst_ended", ispattern, 0);
`ifdef SME_LOADER_TIMEOUT_EN
    n = 0;
    while (!res_valid && n < 300) begin @(posedge clk); #1; n++; end
    check("timeout_cycles", n, 64);
    check("timeout_err", {res_valid, res_match, res_index, res_err}, {1'b1, 1'b0, 5'd0, 1'b1});
`else
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (res_valid) seen++;
    end
    check("no_result_without_timeout", seen, 0);
`endif
    drain();

    check("burst_q_empty", burst_q.size(), 0);
    check("res_q_empty", res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
